// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioning: optional debounce, edge/level detection,
// sticky W1C interrupt status and a masked combined interrupt line.
module gpio_input_conditioner #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic [WIDTH-1:0] debounce_en,
    input  logic [CNT_W-1:0] debounce_limit,
    input  logic [WIDTH-1:0] irq_type,
    input  logic [WIDTH-1:0] irq_pol,
    input  logic [WIDTH-1:0] irq_both,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] status_clr,
    output logic [WIDTH-1:0] gpio_filt,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq_out
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] filtPrev_q;
    logic [WIDTH-1:0] status_q, status_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] riseEvt, fallEvt, setEvt;

    // A differing input must survive limit+1 consecutive edges before it is
    // accepted; the >= compare lets a lowered limit take effect at once.
    always_comb begin
        filt_d = filt_q;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = '0;
            if (!debounce_en[n]) begin
                filt_d[n] = gpio_i[n];
            end else if (gpio_i[n] != filt_q[n]) begin
                if (cnt_q[n] >= debounce_limit) begin
                    filt_d[n] = gpio_i[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CntOne;
                end
            end
        end
    end

    assign riseEvt = filt_q & ~filtPrev_q;
    assign fallEvt = ~filt_q & filtPrev_q;

    always_comb begin
        setEvt = '0;
        for (int n = 0; n < WIDTH; n++) begin
            if (irq_type[n]) begin
                setEvt[n] = irq_pol[n] ? filt_q[n] : ~filt_q[n];
            end else if (irq_both[n]) begin
                setEvt[n] = riseEvt[n] | fallEvt[n];
            end else begin
                setEvt[n] = irq_pol[n] ? riseEvt[n] : fallEvt[n];
            end
        end
    end

    // Set has priority over a coincident clear.
    assign status_d = setEvt | (status_q & ~status_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= '0;
            filtPrev_q <= '0;
            status_q   <= '0;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            filt_q     <= filt_d;
            filtPrev_q <= filt_q;
            status_q   <= status_d;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign gpio_filt  = filt_q;
    assign irq_status = status_q;
    assign irq_out    = |(status_q & irq_en);

`ifndef SYNTHESIS
    // Level mode ignores irq_both, so a bit configured with both is suspect.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(|(irq_type & irq_both)))
            else $error("gpio_input_conditioner: irq_type and irq_both both set (0x%0h)",
                        irq_type & irq_both);
        end
    end
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_gpio_input_conditioner;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] gpio_i;
    logic [WIDTH-1:0] debounce_en;
    logic [CNT_W-1:0] debounce_limit;
    logic [WIDTH-1:0] irq_type;
    logic [WIDTH-1:0] irq_pol;
    logic [WIDTH-1:0] irq_both;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] gpio_filt;
    logic [WIDTH-1:0] irq_status;
    logic             irq_out;

    int compareCount  = 0;
    int mismatchCount = 0;

    gpio_input_conditioner #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .gpio_i         (gpio_i),
        .debounce_en    (debounce_en),
        .debounce_limit (debounce_limit),
        .irq_type       (irq_type),
        .irq_pol        (irq_pol),
        .irq_both       (irq_both),
        .irq_en         (irq_en),
        .status_clr     (status_clr),
        .gpio_filt      (gpio_filt),
        .irq_status     (irq_status),
        .irq_out        (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a run length of consecutive samples that disagree
    // with the accepted value, and an accepted-value history for events.
    logic [WIDTH-1:0] mFilt, mPrev, mStatus;
    int               runLen [WIDTH];

    always @(posedge clk or negedge reset_n) begin
        logic [WIDTH-1:0] newFilt;
        logic [WIDTH-1:0] setNow;
        bit               wasHigh, isHigh;
        if (!reset_n) begin
            mFilt   = '0;
            mPrev   = '0;
            mStatus = '0;
            for (int n = 0; n < WIDTH; n++) runLen[n] = 0;
        end else begin
            newFilt = mFilt;
            setNow  = '0;
            for (int n = 0; n < WIDTH; n++) begin
                if (!debounce_en[n]) begin
                    newFilt[n] = gpio_i[n];
                    runLen[n]  = 0;
                end else if (gpio_i[n] == mFilt[n]) begin
                    runLen[n] = 0;
                end else begin
                    runLen[n] = runLen[n] + 1;
                    if (runLen[n] >= int'(debounce_limit) + 1) begin
                        newFilt[n] = gpio_i[n];
                        runLen[n]  = 0;
                    end
                end
                wasHigh = mPrev[n];
                isHigh  = mFilt[n];
                if (irq_type[n])
                    setNow[n] = (isHigh == irq_pol[n]);
                else if (irq_both[n])
                    setNow[n] = (isHigh != wasHigh);
                else
                    setNow[n] = (isHigh != wasHigh) && (isHigh == irq_pol[n]);
            end
            mStatus = setNow | (mStatus & ~status_clr);
            mPrev   = mFilt;
            mFilt   = newFilt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".filt"},   gpio_filt,  mFilt);
        checkOutput({tag, ".status"}, irq_status, mStatus);
        checkOutput({tag, ".irq"},    irq_out,    |(mStatus & irq_en));
    endtask

    task automatic clearAll();
        status_clr = '1;
        cycle();
        status_clr = '0;
    endtask

    task automatic applyStimulus();
        for (int n = 0; n < WIDTH; n++) begin
            if ($urandom_range(3) == 0) gpio_i[n] = ~gpio_i[n];
        end
        irq_en     = WIDTH'($urandom);
        status_clr = ($urandom_range(3) == 0) ? WIDTH'($urandom) : '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        gpio_i         = '0;
        debounce_en    = '0;
        debounce_limit = '0;
        irq_type       = '0;
        irq_pol        = '1;
        irq_both       = '0;
        irq_en         = '1;
        status_clr     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.filt",   gpio_filt,  8'h00);
        checkOutput("reset.status", irq_status, 8'h00);
        checkOutput("reset.irq",    irq_out,    1'b0);
        reset_n = 1'b1;
        cycle();

        $display("[TB] debounce glitch rejection");
        debounce_en    = 8'h01;
        debounce_limit = 16'd3;
        gpio_i[0]      = 1'b1;
        repeat (3) cycle();
        gpio_i[0] = 1'b0;
        cycle();
        checkOutput("glitch3.filt",   gpio_filt[0],  1'b0);
        checkOutput("glitch3.status", irq_status[0], 1'b0);
        gpio_i[0] = 1'b1;
        repeat (3) cycle();
        checkOutput("glitch4.pre",  gpio_filt[0], 1'b0);
        cycle();
        checkOutput("glitch4.rise", gpio_filt[0], 1'b1);
        gpio_i[0] = 1'b0;
        repeat (5) cycle();
        checkOutput("glitch4.back", gpio_filt[0], 1'b0);
        clearAll();

        $display("[TB] reset during debounce");
        debounce_limit = 16'd5;
        gpio_i[0]      = 1'b1;
        repeat (2) cycle();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst.filt",   gpio_filt,  8'h00);
        checkOutput("midrst.status", irq_status, 8'h00);
        checkOutput("midrst.irq",    irq_out,    1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) cycle();
        checkOutput("midrst.hold", gpio_filt[0], 1'b0);
        cycle();
        checkOutput("midrst.rise", gpio_filt[0], 1'b1);
        gpio_i[0] = 1'b0;
        repeat (7) cycle();
        debounce_en = '0;
        clearAll();
        checkOutput("midrst.clean", irq_status, 8'h00);

        $display("[TB] rising edge interrupt");
        irq_en    = 8'h04;
        gpio_i[2] = 1'b1;
        cycle();
        checkOutput("rise.e1.status", irq_status, 8'h00);
        cycle();
        checkOutput("rise.e2.status", irq_status, 8'h04);
        checkOutput("rise.e2.irq",    irq_out,    1'b1);
        status_clr = 8'h04;
        cycle();
        status_clr = '0;
        checkOutput("rise.clr.status", irq_status, 8'h00);
        checkOutput("rise.clr.irq",    irq_out,    1'b0);
        gpio_i[2] = 1'b0;
        repeat (2) cycle();
        clearAll();

        $display("[TB] set/clear collision");
        irq_both[1] = 1'b1;
        gpio_i[1]   = 1'b1;
        repeat (2) cycle();
        status_clr = 8'h02;
        cycle();
        status_clr = '0;
        checkOutput("coll.pre", irq_status[1], 1'b0);
        gpio_i[1] = 1'b0;
        cycle();
        status_clr = 8'h02;
        cycle();
        status_clr = '0;
        checkOutput("coll.setwins", irq_status[1], 1'b1);
        irq_both[1] = 1'b0;
        clearAll();

        $display("[TB] level mode");
        irq_type[5] = 1'b1;
        gpio_i[5]   = 1'b1;
        repeat (2) cycle();
        status_clr = 8'h20;
        cycle();
        status_clr = '0;
        checkOutput("level.held", irq_status[5], 1'b1);
        gpio_i[5] = 1'b0;
        cycle();
        status_clr = 8'h20;
        cycle();
        status_clr = '0;
        checkOutput("level.clr", irq_status[5], 1'b0);
        irq_type[5] = 1'b0;
        repeat (2) cycle();
        clearAll();

        $display("[TB] masking");
        irq_en    = 8'h00;
        gpio_i[3] = 1'b1;
        repeat (2) cycle();
        checkOutput("mask.status", irq_status, 8'h08);
        checkOutput("mask.irq",    irq_out,    1'b0);
        irq_en = 8'h08;
        #1;
        checkOutput("mask.unmask", irq_out, 1'b1);
        checkModel("directed");

        $display("[TB] randomized traffic");
        for (int phase = 0; phase < 40; phase++) begin
            debounce_en    = WIDTH'($urandom);
            debounce_limit = CNT_W'($urandom_range(4));
            irq_type       = WIDTH'($urandom);
            irq_pol        = WIDTH'($urandom);
            irq_both       = WIDTH'($urandom) & ~irq_type;
            for (int c = 0; c < 50; c++) begin
                applyStimulus();
                cycle();
                checkModel("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Per-bit input conditioning and interrupt stage for the GPIO block. It sits directly downstream of the per-pin bidirectional bit cells and consumes their already-synchronized input bits. For each bit it applies an optional debounce filter, detects edges or levels on the filtered value, and holds sticky interrupt status. The status is cleared by a write-1-to-clear (W1C) pulse. The stage produces one combined interrupt line for the register/bus layer.

## Interface
Parameters:
- WIDTH, 8, number of GPIO bits handled
- CNT_W, 16, width of the debounce counter and limit

Ports:
- clk  input  1  system clock; all state is updated on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- gpio_i  input  WIDTH  synchronized pad inputs from the bit cells; not re-synchronized here
- debounce_en  input  WIDTH  per-bit filter enable
- debounce_limit  input  CNT_W  shared stability limit
- irq_type  input  WIDTH  0 = edge, 1 = level
- irq_pol  input  WIDTH  edge: 1 = rising, 0 = falling; level: 1 = high, 0 = low
- irq_both  input  WIDTH  edge type only: 1 = both edges, overrides irq_pol
- irq_en  input  WIDTH  per-bit interrupt output mask
- status_clr  input  WIDTH  W1C pulse, one cycle per bus write
- gpio_filt  output  WIDTH  conditioned input value (registered)
- irq_status  output  WIDTH  sticky per-bit status (registered)
- irq_out  output  1  |(irq_status & irq_en)

## Operation
- Reset (asynchronous, reset_n low):
  - gpio_filt = 0, filt_d = 0, all counters = 0, irq_status = 0, irq_out = 0.
  - Takes effect immediately, including mid-count; a partial count is discarded.
- Debounce, per bit n, when debounce_en[n] = 1, evaluated each edge:
  - gpio_i[n] == gpio_filt[n]: cnt[n] <= 0.
  - Else, if cnt[n] >= debounce_limit: gpio_filt[n] <= gpio_i[n], cnt[n] <= 0.
  - Else: cnt[n] <= cnt[n] + 1.
  - A new value must therefore be present on debounce_limit+1 consecutive edges. With limit = 0 the filter degenerates to a 1-cycle register.
  - The >= compare means lowering debounce_limit mid-count takes effect without waiting for counter wrap.
  - The counter never exceeds the limit, so it cannot overflow.
- Debounce disabled (debounce_en[n] = 0):
  - gpio_filt[n] <= gpio_i[n] every edge, cnt[n] held at 0.
  - Toggling debounce_en mid-count clears the counter on the next edge.
- Edge detect: filt_d <= gpio_filt every edge.
  - rise = gpio_filt & ~filt_d
  - fall = ~gpio_filt & filt_d
- Set condition set[n]:
  - irq_type = 0 and irq_both = 1: rise | fall
  - irq_type = 0 and irq_both = 0: irq_pol ? rise : fall
  - irq_type = 1: irq_pol ? gpio_filt : ~gpio_filt
- Status update: irq_status[n] <= set[n] | (irq_status[n] & ~status_clr[n]).
  - When set and clear occur in the same cycle, set wins.
  - In level mode, status cannot be cleared while the level condition holds.
  - Status is recorded regardless of irq_en; irq_en masks only irq_out.
- irq_out is combinational from irq_status flops and irq_en, with no other logic in the path.
- Configuration changes apply on the next edge. A change of irq_type or irq_pol does not by itself clear status.
- Assertion (simulation only): flag any cycle in which both irq_type[n] = 1 and irq_both[n] = 1; irq_both is ignored in that case.

## Timing
- Debounce disabled, gpio_i[n] changes before edge E:
  - gpio_filt[n] updates at E.
  - irq_status[n] updates at E+1.
  - irq_out follows in the same cycle as irq_status.
- Debounce enabled with limit L: gpio_filt[n] updates at the (L+1)th consecutive edge sampling the new value; status follows one edge later.
- Edge-mode set is a single-cycle event.
- A status_clr pulse applied at edge C makes status low after C, unless set is active at C.
- No handshake: status_clr is level-sampled each edge. Holding it high for several cycles is equivalent to a single pulse, except that any set in those cycles is preserved.

## Test plan
- Reset values: all outputs are 0 after reset. Assert reset_n mid-debounce with cnt = 2, limit = 5; after release, gpio_filt stays 0 and cnt is 0.
- Debounce glitch rejection: limit = 3, debounce_en = 1, gpio_i[0] pulses high for 3 cycles -> gpio_filt[0] stays 0 and no status. Pulse high for 4 cycles -> gpio_filt[0] rises at the 4th edge.
- Rising edge interrupt: bit 2 edge/rising, irq_en[2] = 1, debounce off, gpio_i[2] 0 -> 1 -> irq_status = 0x04 and irq_out = 1 two edges later. Then status_clr = 0x04 -> status 0, irq_out 0.
- Set/clear collision: bit 1 in both-edge mode; a falling edge coinciding with status_clr[1] -> irq_status[1] remains 1.
- Level mode: bit 5 level-high with gpio_i[5] held 1; status_clr = 0x20 -> status stays 1. Drive gpio_i[5] to 0, clear again -> status 0.
- Masking: bit 3 event with irq_en[3] = 0 -> irq_status[3] = 1, irq_out = 0. Set irq_en[3] = 1 -> irq_out = 1 in the same cycle.
